// File: rtl/op_decode_stage.sv
// op_decode_stage: 9-bit ALU instruction decoder with valid/ready in/out and a 1-entry skid register.
// Defining OP_DECODE_STATS_EN adds saturating alu_cnt/bit_cnt hand-off counters.
module op_decode_stage #(
  parameter int INST_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        op,
  output logic [2:0]        ra,
  output logic [1:0]        rb,
  output logic              reg_write,
  output logic              reads_a,
  output logic              is_bit_op,
  output logic              bit_dir,
  output logic [1:0]        bit_sel
`ifdef OP_DECODE_STATS_EN
  ,
  output logic [CNT_W-1:0]  alu_cnt,
  output logic [CNT_W-1:0]  bit_cnt
`endif
);
  localparam logic [3:0] OP_CLR = 4'd6;

  logic              skid_full_q, skid_full_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        op_q, op_d;
  logic [2:0]        ra_q, ra_d;
  logic [1:0]        rb_q, rb_d;
  logic              reg_write_q, reg_write_d;
  logic              reads_a_q, reads_a_d;
  logic              is_bit_op_q, is_bit_op_d;
  logic              bit_dir_q, bit_dir_d;
  logic [1:0]        bit_sel_q, bit_sel_d;

  logic              accept, handoff, load, load_new;
  logic [INST_W-1:0] src;
  logic [3:0]        src_op;

  always_comb begin
    accept      = in_valid && !skid_full_q;
    handoff     = out_valid_q && out_ready;
    load        = !out_valid_q || out_ready;
    load_new    = load && (skid_full_q || accept);
    // The skid word is always older than anything arriving this cycle.
    src         = skid_full_q ? skid_inst_q : inst;
    src_op      = src[INST_W-1 -: 4];
    out_valid_d = load ? (skid_full_q || accept) : out_valid_q;
    skid_full_d = skid_full_q ? !load : (accept && !load);
    skid_inst_d = (!skid_full_q && accept && !load) ? inst : skid_inst_q;
    op_d        = load_new ? src_op : op_q;
    ra_d        = load_new ? src[4:2] : ra_q;
    rb_d        = load_new ? src[1:0] : rb_q;
    reg_write_d = load_new ? 1'b1 : reg_write_q;
    reads_a_d   = load_new ? (src_op != OP_CLR) : reads_a_q;
    is_bit_op_d = load_new ? src_op[3] : is_bit_op_q;
    bit_dir_d   = load_new ? (src_op[3] & src_op[2]) : bit_dir_q;
    bit_sel_d   = load_new ? (src_op[3] ? src_op[1:0] : 2'd0) : bit_sel_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      skid_full_q <= 1'b0;
      skid_inst_q <= '0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      reg_write_q <= 1'b0;
      reads_a_q   <= 1'b0;
      is_bit_op_q <= 1'b0;
      bit_dir_q   <= 1'b0;
      bit_sel_q   <= '0;
    end else begin
      skid_full_q <= skid_full_d;
      skid_inst_q <= skid_inst_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      reg_write_q <= reg_write_d;
      reads_a_q   <= reads_a_d;
      is_bit_op_q <= is_bit_op_d;
      bit_dir_q   <= bit_dir_d;
      bit_sel_q   <= bit_sel_d;
    end
  end

  assign in_ready  = !skid_full_q;
  assign out_valid = out_valid_q;
  assign op        = op_q;
  assign ra        = ra_q;
  assign rb        = rb_q;
  assign reg_write = reg_write_q;
  assign reads_a   = reads_a_q;
  assign is_bit_op = is_bit_op_q;
  assign bit_dir   = bit_dir_q;
  assign bit_sel   = bit_sel_q;

`ifdef OP_DECODE_STATS_EN
  logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d, bit_cnt_q, bit_cnt_d;

  always_comb begin
    alu_cnt_d = (handoff && !op_q[3] && !(&alu_cnt_q)) ? alu_cnt_q + CNT_W'(1) : alu_cnt_q;
    bit_cnt_d = (handoff &&  op_q[3] && !(&bit_cnt_q)) ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      alu_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      alu_cnt_q <= alu_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign alu_cnt = alu_cnt_q;
  assign bit_cnt = bit_cnt_q;
`else
  logic unused_handoff;
  assign unused_handoff = handoff;
`endif
endmodule

// File: tb/tb_op_decode_stage.sv
// tb_op_decode_stage: randomized and directed checks of op_decode_stage against a queue-based model.
module tb_op_decode_stage;
  logic       Clk = 1'b0;
  logic       Reset, in_valid, in_ready, out_valid, out_ready;
  logic [8:0] inst;
  logic [3:0] op;
  logic [2:0] ra;
  logic [1:0] rb, bit_sel;
  logic       reg_write, reads_a, is_bit_op, bit_dir;
`ifdef OP_DECODE_STATS_EN
  logic [15:0] alu_cnt, bit_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] q[$];
  int exp_alu = 0;
  int exp_bit = 0;

  always #5 Clk = ~Clk;

  op_decode_stage dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready), .op(op), .ra(ra), .rb(rb),
    .reg_write(reg_write), .reads_a(reads_a), .is_bit_op(is_bit_op), .bit_dir(bit_dir),
    .bit_sel(bit_sel)
`ifdef OP_DECODE_STATS_EN
    , .alu_cnt(alu_cnt), .bit_cnt(bit_cnt)
`endif
  );

  // Compare DUT state against the model, drive one cycle, then advance the model.
  task automatic step(input logic v, input logic [8:0] w, input logic r);
    logic acc, ho;
    int   o;
    in_valid = v; inst = w; out_ready = r;
    #1;
    checks++;
    if (out_valid !== (q.size() > 0)) begin
      errors++; $display("FAIL out_valid got %b want %b", out_valid, q.size() > 0);
    end
    checks++;
    if (in_ready !== (q.size() < 2)) begin
      errors++; $display("FAIL in_ready got %b want %b", in_ready, q.size() < 2);
    end
    if (q.size() > 0) begin
      o = int'(q[0][8:5]);
      checks++;
      if ({op, ra, rb} !== q[0]) begin
        errors++; $display("FAIL fields got %h want %h", {op, ra, rb}, q[0]);
      end
      checks++;
      if ({reg_write, reads_a, is_bit_op, bit_dir, bit_sel} !==
          {1'b1, o != 6, o >= 8, o >= 12, (o >= 8) ? 2'(o % 4) : 2'd0}) begin
        errors++; $display("FAIL flags op=%0d got %b%b%b%b%b", o, reg_write, reads_a, is_bit_op, bit_dir, bit_sel);
      end
    end
`ifdef OP_DECODE_STATS_EN
    checks++;
    if (alu_cnt !== 16'(exp_alu) || bit_cnt !== 16'(exp_bit)) begin
      errors++; $display("FAIL counters got %0d/%0d want %0d/%0d", alu_cnt, bit_cnt, exp_alu, exp_bit);
    end
`endif
    acc = v && (q.size() < 2);
    ho  = (q.size() > 0) && r;
    @(posedge Clk);
    if (ho) begin
      if (q[0][8]) exp_bit = (exp_bit < 65535) ? exp_bit + 1 : exp_bit;
      else         exp_alu = (exp_alu < 65535) ? exp_alu + 1 : exp_alu;
      void'(q.pop_front());
    end
    if (acc) q.push_back(w);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1; in_valid = 1'b1; inst = 9'($urandom); out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete(); exp_alu = 0; exp_bit = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hs got v=%b r=%b want 0/1", out_valid, in_ready);
    end
    checks++;
    if ({op, ra, rb, reg_write, reads_a, is_bit_op, bit_dir, bit_sel} !== 16'd0) begin
      errors++; $display("FAIL reset_fields got %h want 0", {op, ra, rb, reg_write, reads_a, is_bit_op, bit_dir, bit_sel});
    end
  endtask

  task automatic test_reset();
    do_reset();
    step(0, 9'd0, 1);
  endtask

  task automatic test_directed();
    step(1, 9'b0000_011_01, 1);
    checks++;
    if (out_valid !== 1'b1 || op !== 4'd0 || ra !== 3'd3 || rb !== 2'd1 || reads_a !== 1'b1 || is_bit_op !== 1'b0) begin
      errors++; $display("FAIL add got v=%b op=%0d ra=%0d rb=%0d", out_valid, op, ra, rb);
    end
    step(1, 9'b0110_101_00, 1);
    checks++;
    if (op !== 4'd6 || reads_a !== 1'b0 || reg_write !== 1'b1) begin
      errors++; $display("FAIL clr got op=%0d reads_a=%b reg_write=%b", op, reads_a, reg_write);
    end
    step(1, 9'b1110_001_10, 1);
    checks++;
    if (is_bit_op !== 1'b1 || bit_dir !== 1'b1 || bit_sel !== 2'd2 || rb !== 2'd2) begin
      errors++; $display("FAIL db3 got bit=%b dir=%b sel=%0d rb=%0d", is_bit_op, bit_dir, bit_sel, rb);
    end
    step(0, 9'd0, 1);
  endtask

  task automatic test_backpressure();
    step(1, 9'b0000_001_01, 0);
    step(1, 9'b1001_010_10, 0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full in_ready got %b want 0", in_ready);
    end
    step(1, 9'b1111_111_11, 0);
    step(1, 9'b1111_111_11, 1);
    step(1, 9'b1111_111_11, 1);
    step(0, 9'd0, 1);
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain got v=%b left=%0d want 0", out_valid, q.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step(1, 9'($urandom), 1);
    step(0, 9'd0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 9'($urandom), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 3; i++) step(0, 9'd0, 1);
  endtask

  task automatic test_reset_mid();
    step(1, 9'b0010_100_11, 0);
    step(1, 9'b1100_011_00, 0);
    do_reset();
    step(0, 9'd0, 1);
  endtask

`ifdef OP_DECODE_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 9'b0000_000_00, 1);
    for (int i = 0; i < 2; i++) step(1, 9'b1000_000_00, 1);
    step(0, 9'd0, 1);
    checks++;
    if (alu_cnt !== 16'd3 || bit_cnt !== 16'd2) begin
      errors++; $display("FAIL stats got %0d/%0d want 3/2", alu_cnt, bit_cnt);
    end
    for (int i = 0; i < 65540; i++) step(1, 9'b0001_000_00, 1);
    step(0, 9'd0, 1);
    checks++;
    if (alu_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat got %h want ffff", alu_cnt);
    end
  endtask
`endif

  initial begin
    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inst = '0;
    @(negedge Clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef OP_DECODE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
